// File: rtl/ram_word_adapter_if.sv
// Core/RAM-side bus of the 16-bit-to-byte RAM access sequencer.
// The slave modport is the adapter. The master modport is its environment: the core plus the RAM.
interface ram_word_adapter_if;
  logic        start;
  logic        write;
  logic        word;
  logic [11:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        busy;
  logic        done;
  logic [11:0] ram_address;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic        ram_write_enable;

  modport master (
    output start, write, word, address, data_in, ram_data_out,
    input  data_out, busy, done, ram_address, ram_data_in, ram_write_enable
  );

  modport slave (
    input  start, write, word, address, data_in, ram_data_out,
    output data_out, busy, done, ram_address, ram_data_in, ram_write_enable
  );
endinterface

// File: rtl/ram_word_adapter.sv
// Splits one byte or little-endian 16-bit core request into one or two byte accesses on a 4096 x 8 RAM.
// Every output is a register that is loaded on the edge that enters the state using it.
module ram_word_adapter (
  input  logic               clk,
  input  logic               reset_n,
  ram_word_adapter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_LO_CAP, RD_HI, RD_HI_CAP, WR_LO, WR_HI, DONE
  } state_e;

  state_e      state_q;
  logic        word_q;
  logic [11:0] addr_q;
  logic [7:0]  data_hi_q;
  logic [15:0] data_out_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] ram_address_q;
  logic [7:0]  ram_data_in_q;
  logic        ram_we_q;
  logic [11:0] addr_hi_d;

  // The 12-bit add wraps, so a word at 0xFFF takes its high byte from 0x000.
  assign addr_hi_d = addr_q + 12'd1;

  // NOTE: use non-blocking assignments in clocked blocks. Every register then updates
  // from pre-edge values, and the order of statements inside the block does not matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      word_q        <= 1'b0;
      addr_q        <= '0;
      data_hi_q     <= '0;
      data_out_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      ram_we_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            word_q        <= bus.word;
            addr_q        <= bus.address;
            data_hi_q     <= bus.data_in[15:8];
            busy_q        <= 1'b1;
            ram_address_q <= bus.address;
            if (bus.write) begin
              ram_data_in_q <= bus.data_in[7:0];
              ram_we_q      <= 1'b1;
              state_q       <= WR_LO;
            end else begin
              ram_we_q      <= 1'b0;
              state_q       <= RD_LO;
            end
          end
        end
        RD_LO: state_q <= RD_LO_CAP;
        RD_LO_CAP: begin
          data_out_q[7:0] <= bus.ram_data_out;
          if (word_q) begin
            ram_address_q <= addr_hi_d;
            state_q       <= RD_HI;
          end else begin
            data_out_q[15:8] <= 8'h00;
            busy_q           <= 1'b0;
            done_q           <= 1'b1;
            state_q          <= DONE;
          end
        end
        RD_HI: state_q <= RD_HI_CAP;
        RD_HI_CAP: begin
          data_out_q[15:8] <= bus.ram_data_out;
          busy_q           <= 1'b0;
          done_q           <= 1'b1;
          state_q          <= DONE;
        end
        WR_LO: begin
          if (word_q) begin
            ram_address_q <= addr_hi_d;
            ram_data_in_q <= data_hi_q;
            state_q       <= WR_HI;
          end else begin
            ram_we_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        WR_HI: begin
          ram_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: state_q <= IDLE;
        default: begin
          ram_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out         = data_out_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.ram_address      = ram_address_q;
  assign bus.ram_data_in      = ram_data_in_q;
  assign bus.ram_write_enable = ram_we_q;

endmodule

// File: tb/tb_ram_word_adapter.sv
// Directed bench for ram_word_adapter. It uses a behavioural 4096 x 8 RAM with an asynchronous read
// and a write on the rising edge.
module tb_ram_word_adapter;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_mis;

  ram_word_adapter_if bus ();

  ram_word_adapter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic [7:0] mem [4096];

  assign bus.ram_data_out = mem[bus.ram_address];

  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and monitors it until it completes or times out.
  // done_idx is the number of edges after E0 at which done is seen.
  task automatic run_req(
    input  logic        wr,
    input  logic        wd,
    input  logic [11:0] a,
    input  logic [15:0] d,
    input  bit          pulse_start,
    input  bit          hold_check,
    input  logic [15:0] hold_val,
    output int          done_idx,
    output int          done_cnt,
    output int          we_cnt,
    output logic [11:0] we_addr0,
    output int          rd_we_viol
  );
    done_idx   = -1;
    done_cnt   = 0;
    we_cnt     = 0;
    we_addr0   = '0;
    rd_we_viol = 0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.write   = wr;
    bus.word    = wd;
    bus.address = a;
    bus.data_in = d;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (pulse_start) begin
        bus.start   = 1'b1;
        bus.write   = 1'b1;
        bus.word    = 1'b1;
        bus.address = 12'h555;
        bus.data_in = 16'hDEAD;
      end else begin
        bus.start = 1'b0;
      end
      if (k == 0) check("busy_first", {31'b0, bus.busy}, 32'd1);
      if (bus.ram_write_enable) begin
        if (we_cnt == 0) we_addr0 = bus.ram_address;
        we_cnt++;
        if (!wr) rd_we_viol++;
      end
      if (hold_check) check("data_hold", {16'b0, bus.data_out}, {16'b0, hold_val});
      if (bus.done) begin
        done_idx = k;
        done_cnt++;
        check("busy_at_done", {31'b0, bus.busy}, 32'd0);
        check("we_at_done", {31'b0, bus.ram_write_enable}, 32'd0);
        break;
      end
    end
    // The adapter should now be back in IDLE with nothing left in progress.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) done_cnt++;
      if (bus.ram_write_enable) we_cnt++;
      if (k == 1) check("busy_after", {31'b0, bus.busy}, 32'd0);
    end
  endtask

  int          di, dc, wc, viol;
  logic [11:0] wa0;
  int          extra_done, extra_busy;

  initial begin
    n_cmp       = 0;
    n_mis       = 0;
    bus.start   = 1'b0;
    bus.write   = 1'b0;
    bus.word    = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h300] = 8'h11;
    mem[12'h301] = 8'h22;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_we", {31'b0, bus.ram_write_enable}, 32'd0);
    check("rst_data_out", {16'b0, bus.data_out}, 32'd0);
    check("rst_ram_addr", {20'b0, bus.ram_address}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Word write 0xBEEF to 0x200, then read it back.
    run_req(1'b1, 1'b1, 12'h200, 16'hBEEF, 1'b0, 1'b0, 16'h0, di, dc, wc, wa0, viol);
    check("ww_done_idx", di, 32'd2);
    check("ww_done_cnt", dc, 32'd1);
    check("ww_we_cnt", wc, 32'd2);
    check("ww_we_addr", {20'b0, wa0}, 32'h200);
    check("ww_mem_lo", {24'b0, mem[12'h200]}, 32'hEF);
    check("ww_mem_hi", {24'b0, mem[12'h201]}, 32'hBE);
    run_req(1'b0, 1'b1, 12'h200, 16'h0, 1'b0, 1'b0, 16'h0, di, dc, wc, wa0, viol);
    check("wr_done_idx", di, 32'd4);
    check("wr_done_cnt", dc, 32'd1);
    check("wr_data", {16'b0, bus.data_out}, 32'hBEEF);
    check("wr_no_we", wc, 32'd0);

    // Byte write 0xA5 to 0x123; the read data must hold 0xBEEF throughout.
    run_req(1'b1, 1'b0, 12'h123, 16'h77A5, 1'b0, 1'b1, 16'hBEEF, di, dc, wc, wa0, viol);
    check("bw_done_idx", di, 32'd1);
    check("bw_we_cnt", wc, 32'd1);
    check("bw_we_addr", {20'b0, wa0}, 32'h123);
    check("bw_mem", {24'b0, mem[12'h123]}, 32'hA5);
    check("bw_mem_next", {24'b0, mem[12'h124]}, 32'h00);
    run_req(1'b0, 1'b0, 12'h123, 16'h0, 1'b0, 1'b0, 16'h0, di, dc, wc, wa0, viol);
    check("br_done_idx", di, 32'd2);
    check("br_data", {16'b0, bus.data_out}, 32'h00A5);
    check("br_rd_we", viol, 32'd0);

    // Word write at 0xFFF wraps its high byte to 0x000.
    run_req(1'b1, 1'b1, 12'hFFF, 16'h1234, 1'b0, 1'b0, 16'h0, di, dc, wc, wa0, viol);
    check("wrap_mem_lo", {24'b0, mem[12'hFFF]}, 32'h34);
    check("wrap_mem_hi", {24'b0, mem[12'h000]}, 32'h12);
    run_req(1'b0, 1'b1, 12'hFFF, 16'h0, 1'b0, 1'b0, 16'h0, di, dc, wc, wa0, viol);
    check("wrap_rd_data", {16'b0, bus.data_out}, 32'h1234);

    // Word read of 0x300 while start is held high with a conflicting write request.
    run_req(1'b0, 1'b1, 12'h300, 16'h0, 1'b1, 1'b0, 16'h0, di, dc, wc, wa0, viol);
    check("ign_done_idx", di, 32'd4);
    check("ign_done_cnt", dc, 32'd1);
    check("ign_data", {16'b0, bus.data_out}, 32'h2211);
    check("ign_no_we", wc, 32'd0);
    check("ign_mem_555", {24'b0, mem[12'h555]}, 32'h00);

    // Reset while the word write is in WR_HI.
    mem[12'h401] = 8'h5A;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.write   = 1'b1;
    bus.word    = 1'b1;
    bus.address = 12'h400;
    bus.data_in = 16'hCAFE;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("wrhi_addr", {20'b0, bus.ram_address}, 32'h401);
    check("wrhi_we", {31'b0, bus.ram_write_enable}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_we", {31'b0, bus.ram_write_enable}, 32'd0);
    check("arst_busy", {31'b0, bus.busy}, 32'd0);
    check("arst_data_out", {16'b0, bus.data_out}, 32'd0);
    check("arst_ram_addr", {20'b0, bus.ram_address}, 32'd0);
    check("arst_ram_din", {24'b0, bus.ram_data_in}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    extra_done = 0;
    extra_busy = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
      if (bus.busy) extra_busy++;
    end
    check("arst_no_done", extra_done, 32'd0);
    check("arst_idle", extra_busy, 32'd0);
    check("arst_mem_lo", {24'b0, mem[12'h400]}, 32'hFE);
    check("arst_mem_hi", {24'b0, mem[12'h401]}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
